// File: rtl/div_ctrl.sv
// Execute-stage sequencer for the multicycle 64-bit divider (RV64M DIV/DIVU/REM/REMU and W forms).
// Prepares operands, handles divide-by-zero/overflow locally, and drives the divider handshake.
module div_ctrl #(
    parameter int unsigned TIMEOUT = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  funct3,
    input  logic        is_word,
    input  logic [63:0] rs1,
    input  logic [63:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic        result_valid,
    output logic [63:0] result,
    output logic        div_err,
    output logic        div_start,
    output logic        div_signed_dividend,
    output logic        div_signed_divisor,
    output logic [63:0] div_dividend,
    output logic [63:0] div_divisor,
    input  logic [63:0] div_quotient,
    input  logic [63:0] div_remainder,
    input  logic        div_ready
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   dividend_q, dividend_d;
    logic [63:0]   divisor_q, divisor_d;
    logic          signed_q, signed_d;
    logic          rem_sel_q, rem_sel_d;
    logic          word_q, word_d;
    logic [63:0]   result_q, result_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic          sgn;
    logic [63:0]   opa, opb, min_neg;
    logic          div_zero, ovf;
    logic          unused_f3;

    // funct3[2] is always set for divide ops; only bits [1:0] carry meaning here
    assign unused_f3 = funct3[2];

    function automatic logic [63:0] finish_val(input logic [63:0] v, input logic w);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        sgn     = ~funct3[0];
        opa     = rs1;
        opb     = rs2;
        if (is_word) begin
            opa = {{32{sgn & rs1[31]}}, rs1[31:0]};
            opb = {{32{sgn & rs2[31]}}, rs2[31:0]};
        end
        min_neg  = is_word ? {{33{1'b1}}, 31'b0} : {1'b1, 63'b0};
        div_zero = (opb == '0);
        ovf      = sgn && (opb == '1) && (opa == min_neg);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        rem_sel_d  = rem_sel_q;
        word_d     = word_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    dividend_d = opa;
                    divisor_d  = opb;
                    signed_d   = sgn;
                    rem_sel_d  = funct3[1];
                    word_d     = is_word;
                    if (div_zero || ovf) begin
                        // Zero divisor: q = all ones, r = dividend; overflow: q = dividend, r = 0
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = finish_val(funct3[1] ? (div_zero ? opa : '0)
                                                        : (div_zero ? '1 : opa), is_word);
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div_ready) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = finish_val(rem_sel_q ? div_remainder : div_quotient, word_q);
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    err_d    = 1'b1;
                    result_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            rem_sel_q  <= 1'b0;
            word_q     <= 1'b0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            rem_sel_q  <= rem_sel_d;
            word_q     <= word_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign stall               = (state_q == RUN) | ((state_q == IDLE) & req_valid & ~flush);
    assign div_start           = (state_q == RUN);
    assign div_signed_dividend = signed_q;
    assign div_signed_divisor  = signed_q;
    assign div_dividend        = dividend_q;
    assign div_divisor         = divisor_q;
    assign result              = result_q;
    assign result_valid        = valid_q;
    assign div_err             = err_q;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Initiator-side sequencer for the multicycle 64-bit divider in the execute stage. Implements RV64M DIV/DIVU/REM/REMU and the W forms.
- Decodes the request and prepares the operands, including 32-bit extension for W ops.
- Drives the divider start/ready handshake and stalls the pipeline while the divider runs.
- Resolves divide-by-zero and signed overflow locally without engaging the divider, then selects and sign-extends the result.

Parameters:
- TIMEOUT, 127: maximum RUN cycles to wait for div_ready before aborting with div_err.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  EX-stage divide instruction present
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- is_word  in  1  W-form op (DIVW, DIVUW, REMW, REMUW)
- rs1  in  64  dividend operand
- rs2  in  64  divisor operand
- flush  in  1  kill in-flight op
- stall  out  1  hold pipeline
- result_valid  out  1  one-cycle result strobe
- result  out  64  rd write data
- div_err  out  1  one-cycle timeout flag, coincident with result_valid
- div_start  out  1  to divider start; held high for whole operation
- div_signed_dividend  out  1  to divider
- div_signed_divisor  out  1  to divider
- div_dividend  out  64  to divider
- div_divisor  out  64  to divider
- div_quotient  in  64  from divider
- div_remainder  in  64  from divider
- div_ready  in  1  from divider; completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-operation drops div_start immediately and discards the op.
- FSM states: IDLE, RUN, DONE.
- IDLE: samples req_valid; other states ignore req_valid.
- Operand prep on acceptance, registered into op regs:
  - signed = !funct3[0].
  - W ops: operands = rs[31:0], sign-extended if signed, zero-extended if unsigned.
  - div_signed_dividend = div_signed_divisor = signed.
- Special cases, checked on the prepared operands:
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed overflow: signed, divisor == all ones, dividend == most-negative value (64-bit 0x8000_0000_0000_0000; W ops 0xFFFF_FFFF_8000_0000 after extension). Quotient = dividend; remainder = 0.
  - Either case: IDLE -> DONE; div_start never asserts.
- Normal path: IDLE -> RUN. div_start = 1 and div_* operands stable every RUN cycle. Timeout counter clears on entry and increments each RUN cycle.
- RUN exits:
  - div_ready = 1 sampled at an edge: capture div_quotient/div_remainder, go to DONE. div_start is 0 in DONE so the divider does not rerun.
  - flush = 1: go to IDLE with no result_valid; div_start falls the next cycle.
  - Counter == TIMEOUT: go to DONE with result = 0 and div_err = 1.
  - Precedence: reset > flush > div_ready > timeout.
- DONE, one cycle:
  - result_valid = 1, stall = 0, div_start = 0.
  - result = funct3[1] ? remainder : quotient.
  - W ops: result = sign-extend of selected[31:0], for both signed and unsigned.
  - Next state is IDLE.
  - flush in DONE: result_valid is still asserted; the pipeline's own kill applies.
- stall is combinational: (state == RUN) | (state == IDLE & req_valid & !flush). It falls in the DONE cycle.
- Latency:
  - Special case: req in cycle N, result_valid in N+1.
  - Normal: div_ready sampled at the cycle-M edge, result_valid in M+1.
- Back-to-back ops: IDLE always separates two div_start high periods, giving at least one cycle of div_start = 0 so the divider clears its state.
- result, div_err and result_valid are registered. result holds its value until the next DONE.

Test Plan:
- Bench uses a behavioural divider with 66-cycle latency.
- DIV rs1 = -7, rs2 = 2 -> result -3 (0xFFFF_FFFF_FFFF_FFFD). REM same operands -> -1. div_start high exactly until ready; stall drops in the result_valid cycle.
- DIVU rs1 = 100, rs2 = 7 -> 14; REMU -> 2. div_signed_* = 0 while running.
- DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF; REM 5/0 -> 5. result_valid 1 cycle after req; div_start never 1.
- DIVW rs1 = 0x0000_0000_8000_0000, rs2 = 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000; REMW same -> 0.
- DIVUW rs1 = 0xFFFF_FFFF_FFFF_FFFE, rs2 = 1 -> 0xFFFF_FFFF_FFFF_FFFE (sign-extended from bit 31).
- Flush at RUN cycle 10 -> no result_valid, div_start low next cycle. Immediate new DIV 9/3 -> 3 with one start-low gap.
- Stub divider never asserts ready -> after TIMEOUT RUN cycles, result_valid = 1, div_err = 1, result = 0.
- Assert rst mid-RUN -> all outputs 0 immediately; state IDLE.
